ps2_host_tx: RTL
================

// Module: ps2_host_tx
// PURPOSE
//  PS/2 host-to-device transmitter. Sends one command byte to the keyboard, e.g. 0xED (set LEDs) or 0xF4 (enable).
//  Drives the open-drain PS2_CLK/PS2_DAT lines through active-high pull-low enables.
//  Sits beside the PS/2 scan-code receiver on the same pins. While busy=1 the receiver must ignore line activity.
// PARAMETERS
//  INHIBIT_CYCLES  6000       clock cycles CLK is held low for request-to-send (120 us @ 50 MHz)
//  TIMEOUT_CYCLES  1000000    max cycles between device CLK falling edges before abort (20 ms @ 50 MHz)
// PORTS
//  clock        in   1  system clock, 50 MHz
//  reset        in   1  asynchronous, active-high reset
//  tx_data      in   8  command byte; sampled when tx_valid && tx_ready
//  tx_valid     in   1  request to send tx_data
//  tx_ready     out  1  1 = idle, can accept a byte
//  busy         out  1  1 = transfer in progress (equals ~tx_ready)
//  PS2_CLK_in   in   1  PS/2 clock line, raw
//  PS2_DAT_in   in   1  PS/2 data line, raw
//  ps2_clk_oe   out  1  1 = pull PS2_CLK low; 0 = release
//  ps2_dat_oe   out  1  1 = pull PS2_DAT low; 0 = release
//  done         out  1  one-cycle pulse: byte sent and device ACK seen
//  error        out  1  one-cycle pulse: NACK or timeout
// BEHAVIOUR
//  Reset (async): state=IDLE, tx_ready=1, busy=0, ps2_clk_oe=0, ps2_dat_oe=0, done=0, error=0.
//   Both lines are released immediately, including mid-transfer.
//  Line inputs: each passes a 2-FF synchronizer on clock. A device CLK fall is sync_prev=1 && sync_cur=0.
//  Accept: tx_valid && tx_ready latches tx_data and parity P = ~^tx_data (odd parity). The next state is INHIBIT.
//   tx_valid while busy is ignored; the byte is not queued.
//  States:
//   IDLE     both lines released. tx_ready=1.
//   INHIBIT  ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles.
//            In the last of these cycles also assert ps2_dat_oe=1 (start bit).
//            Then clear ps2_clk_oe (dat stays low) and go to START.
//   START    wait for CLK fall #1, then drive D0 and go to DATA. Bit is 0 => dat_oe=1; bit is 1 => dat_oe=0.
//   DATA     on falls #2..#8 drive D1..D7 (LSB first). After fall #8 go to PARITY.
//   PARITY   on fall #9 drive P. Go to STOP.
//   STOP     on fall #10 release DAT (dat_oe=0). Go to ACK.
//   ACK      on fall #11 sample synced DAT. 0 => done pulse; 1 => error pulse (NACK). Go to WAIT_IDLE.
//   WAIT_IDLE  wait until synced CLK=1 and DAT=1, then go to IDLE (tx_ready=1 the following cycle).
//  Bit counter: 4 bits, counts falls 1..11, cleared on accept.
//  Timeout: counter cleared on accept and on every CLK fall.
//   In START..ACK and WAIT_IDLE, reaching TIMEOUT_CYCLES releases both lines, pulses error and goes to IDLE.
//  done and error never assert in the same cycle. Each is high for exactly 1 cycle.
//  Line-edge latency: output change appears 3 clock cycles after the raw CLK fall (2 sync + 1 register).
// CONFIGURATION
//  PS2_TX_RETRY_EN defined:
//   On NACK or timeout, suppress the first error pulse and restart at INHIBIT with the same latched byte.
//   A second failure pulses error and returns to IDLE. busy stays 1 across the retry.
//  PS2_TX_RETRY_EN undefined: every NACK or timeout pulses error and returns to IDLE. No retry logic.
// TESTING
//  Send 0xED (six ones). Device model clocks at 12.5 kHz and ACKs. Required response:
//   CLK low 6000 cycles, then DAT bits 1,0,1,1,0,1,1,1, parity 1, stop released, done=1 once.
//  Send 0xF4 (five ones). Required response: parity bit 0 on fall #9, done=1.
//  Device holds DAT=1 at fall #11 (NACK). Required response: error=1 once, done=0, back to IDLE.
//   With PS2_TX_RETRY_EN: a second INHIBIT occurs, and error fires only after the second NACK.
//  Device stops clocking after fall #4. Required response:
//   error=1 exactly TIMEOUT_CYCLES after the last fall, oe outputs both 0, tx_ready=1.
//  Assert reset at fall #6. Required response: ps2_clk_oe=ps2_dat_oe=0 in the same cycle.
//   After release, a new 0x55 sends cleanly.
//  Pulse tx_valid with 0xAA during a 0xED transfer. Required response: 0xAA is ignored, 0xED completes unchanged.

Source files
------------

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter driving open-drain lines via pull-low enables.
// Define PS2_TX_RETRY_EN to retry a failed byte once before reporting error.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 6000,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       busy,
   input  logic       PS2_CLK_in,
   input  logic       PS2_DAT_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe,
   output logic       done,
   output logic       error
);
   localparam int MAXC = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
   localparam int CW = $clog2(MAXC + 1);
   typedef enum logic [2:0] {IDLE, INHIBIT, START, DATA, PARITY, STOP, ACK, WAIT_IDLE} state_t;
   state_t state_q;
   logic [2:0] clk_sync_q;
   logic [1:0] dat_sync_q;
   logic [7:0] data_q;
   logic par_q;
   logic [3:0] bit_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic clk_oe_q, dat_oe_q, done_q, error_q;
   logic clk_fall, dat_s, accept, timed, fail, retry;
   // clk_sync_q[1] is the synchronized line, clk_sync_q[2] its previous value
   assign clk_fall = clk_sync_q[2] & ~clk_sync_q[1];
   assign dat_s = dat_sync_q[1];
   assign accept = (state_q == IDLE) & tx_valid;
   assign timed = (state_q != IDLE) & (state_q != INHIBIT);
   assign cnt_d = clk_fall ? '0 : cnt_q + 1'b1;
   assign fail = timed & ((~clk_fall & (cnt_q == CW'(TIMEOUT_CYCLES - 1))) |
                          (clk_fall & (state_q == ACK) & dat_s));
   assign tx_ready = (state_q == IDLE);
   assign busy = ~tx_ready;
   assign ps2_clk_oe = clk_oe_q;
   assign ps2_dat_oe = dat_oe_q;
   assign done = done_q;
   assign error = error_q;
`ifdef PS2_TX_RETRY_EN
   logic retried_q;
   assign retry = ~retried_q;
   always_ff @(posedge clock or posedge reset)
      if (reset) retried_q <= 1'b0;
      else if (accept) retried_q <= 1'b0;
      else if (fail) retried_q <= 1'b1;
`else
   assign retry = 1'b0;
`endif
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         clk_sync_q <= '1;
         dat_sync_q <= '1;
         data_q <= '0;
         par_q <= 1'b0;
         bit_q <= '0;
         cnt_q <= '0;
         clk_oe_q <= 1'b0;
         dat_oe_q <= 1'b0;
         done_q <= 1'b0;
         error_q <= 1'b0;
      end else begin
         clk_sync_q <= {clk_sync_q[1:0], PS2_CLK_in};
         dat_sync_q <= {dat_sync_q[0], PS2_DAT_in};
         done_q <= 1'b0;
         error_q <= 1'b0;
         if (fail && retry) begin
            state_q <= INHIBIT;
            clk_oe_q <= 1'b1;
            dat_oe_q <= 1'b0;
            cnt_q <= '0;
            bit_q <= '0;
         end else if (fail) begin
            state_q <= IDLE;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            error_q <= 1'b1;
         end else case (state_q)
            IDLE: begin
               clk_oe_q <= 1'b0;
               dat_oe_q <= 1'b0;
               if (accept) begin
                  data_q <= tx_data;
                  par_q <= ~^tx_data;
                  bit_q <= '0;
                  cnt_q <= '0;
                  clk_oe_q <= 1'b1;
                  state_q <= INHIBIT;
               end
            end
            INHIBIT: begin
               if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
                  clk_oe_q <= 1'b0;
                  cnt_q <= '0;
                  state_q <= START;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
                  if (cnt_q == CW'(INHIBIT_CYCLES - 2)) dat_oe_q <= 1'b1;
               end
            end
            default: begin
               cnt_q <= cnt_d;
               if (clk_fall) bit_q <= bit_q + 1'b1;
               if (state_q == WAIT_IDLE && clk_sync_q[1] && dat_s) state_q <= IDLE;
               else if (clk_fall) case (state_q)
                  START: begin
                     dat_oe_q <= ~data_q[0];
                     state_q <= DATA;
                  end
                  DATA: begin
                     dat_oe_q <= ~data_q[bit_q[2:0]];
                     if (bit_q == 4'd7) state_q <= PARITY;
                  end
                  PARITY: begin
                     dat_oe_q <= ~par_q;
                     state_q <= STOP;
                  end
                  STOP: begin
                     dat_oe_q <= 1'b0;
                     state_q <= ACK;
                  end
                  ACK: begin
                     done_q <= 1'b1;
                     state_q <= WAIT_IDLE;
                  end
                  default: ;
               endcase
            end
         endcase
      end
   end
endmodule
